// File: rtl/lb_stream_if.sv
// Stream-in / memory-core handshake bundle for the line-buffer sequencer.
// The controller takes the slave side; the stream source and memory core take the master side.
interface lb_stream_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic              out_valid;

    modport master (
        output in_valid,
        input  in_ready, mem_wen, mem_waddr, mem_ren, mem_raddr, out_valid
    );

    modport slave (
        input  in_valid,
        output in_ready, mem_wen, mem_waddr, mem_ren, mem_raddr, out_valid
    );
endinterface

// File: rtl/lb_stream_ctrl.sv
// Line-buffer sequencer: fills a circular window of depth_q words, then pairs one read
// with every write, and empties the window on drain_req.
module lb_stream_ctrl #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] depth,
    input  logic              drain_req,
    lb_stream_if.slave        bus,
    output logic [CNT_W-1:0]  occupancy,
    output logic              full,
    output logic              empty,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FILL, STEADY, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W-1:0] depth_q;
    logic [RD_LAT-1:0] vld_p;

    logic              clr;
    logic              active;
    logic              ready;
    logic              wr;
    logic              ren;
    logic [ADDR_W-1:0] depth_eff;
    logic [ADDR_W-1:0] depth_use;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr,
                                                   input logic [ADDR_W-1:0] lim);
        return (ptr == lim - ADDR_W'(1)) ? '0 : ptr + ADDR_W'(1);
    endfunction

    assign clr       = ~reset | flush;
    assign active    = ~clr & clk_en;
    assign depth_eff = (depth == '0) ? ADDR_W'(1) : depth;
    // The first write in IDLE must already wrap against the depth it is about to latch.
    assign depth_use = (state == IDLE) ? depth_eff : depth_q;

    always_comb begin
        ready = active && (state != DRAIN);
        wr    = bus.in_valid & ready;
        ren   = 1'b0;
        if (active) begin
            if (state == STEADY)
                ren = wr;
            else if (state == DRAIN)
                ren = (occupancy != '0);
        end
        done = active && (state == DRAIN) && (occupancy == CNT_W'(1));
    end

    assign bus.in_ready  = ready;
    assign bus.mem_wen   = wr;
    assign bus.mem_waddr = wptr;
    assign bus.mem_ren   = ren;
    assign bus.mem_raddr = rptr;
    assign bus.out_valid = ~clr & vld_p[RD_LAT-1];

    assign full  = ~clr && (occupancy == CNT_W'(depth_q));
    assign empty = clr || (occupancy == '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
            depth_q   <= ADDR_W'(1);
            vld_p     <= '0;
        end else if (clk_en) begin
            // read-latency stage boundary: out_valid trails mem_ren by RD_LAT enabled cycles
            vld_p[0] <= ren;
            for (int i = 1; i < RD_LAT; i++)
                vld_p[i] <= vld_p[i-1];

            if (wr)
                wptr <= next_ptr(wptr, depth_use);
            if (ren)
                rptr <= next_ptr(rptr, depth_q);
            occupancy <= occupancy + CNT_W'(wr) - CNT_W'(ren);

            case (state)
                IDLE: begin
                    if (wr) begin
                        depth_q <= depth_eff;
                        state   <= (depth_eff == ADDR_W'(1)) ? STEADY : FILL;
                    end
                end
                FILL: begin
                    if (drain_req)
                        state <= DRAIN;
                    else if (wr && (occupancy + CNT_W'(1) == CNT_W'(depth_q)))
                        state <= STEADY;
                end
                STEADY: begin
                    if (drain_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Window empty: restart both pointers so a new depth starts cleanly.
                    if (occupancy == CNT_W'(1)) begin
                        state <= IDLE;
                        wptr  <= '0;
                        rptr  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lb_stream_ctrl.md
Name: lb_stream_ctrl

Overview:
- Sequencer for the memory core in line-buffer mode.
- Accepts a write stream and generates the core's write enable, write address, read enable and read address over a circular window of `depth` words.
- Holds off reads until the window is full, then issues one read per write (rate-matched), and drains the remaining window on request.
- Sits between the upstream stream source and the memory core; tracks occupancy and status.

Parameters:
- ADDR_W, 16, width of SRAM word addresses and of depth.
- CNT_W, 17, width of the occupancy counter; must be at least ADDR_W+1.
- RD_LAT, 1, cycles from mem_ren to valid read data at the core output (1..4).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- clk_en  input  1  global clock enable; when low, all state holds.
- flush  input  1  synchronous soft clear; same effect as reset.
- depth  input  ADDR_W  line-buffer window length in words.
- in_valid  input  1  upstream word present.
- in_ready  output  1  controller accepts the word this cycle.
- drain_req  input  1  end-of-stream; empty the window.
- mem_wen  output  1  write enable to memory core.
- mem_waddr  output  ADDR_W  write address.
- mem_ren  output  1  read enable to memory core.
- mem_raddr  output  ADDR_W  read address.
- out_valid  output  1  mem_ren delayed by RD_LAT; qualifies core data_out.
- occupancy  output  CNT_W  words currently held.
- full  output  1  occupancy == depth_q.
- empty  output  1  occupancy == 0.
- done  output  1  one-cycle pulse when a drain completes.

Behaviour:
- Reset is synchronous, active-low: `reset == 0` at a posedge clears all state.
- Priority: reset > flush > clk_en.
  - Reset or flush: state=IDLE, wptr=rptr=0, occupancy=0, depth_q=1, latency pipe cleared.
  - Outputs during reset/flush: in_ready=0, mem_wen=mem_ren=0, out_valid=0, done=0, empty=1, full=0.
- clk_en=0: registers hold; in_ready, mem_wen and mem_ren are forced 0; the out_valid pipe does not advance.
- Let `wr = in_valid & in_ready`. Then mem_wen=wr and mem_waddr=wptr, both combinational.
- depth_q is latched from depth on the first accepted write in IDLE. A depth of 0 is latched as 1. Later changes to depth are ignored until the controller returns to IDLE.
- States:
  - IDLE: in_ready=1. On wr, go to FILL with occupancy=1, or straight to STEADY if the effective depth is 1. drain_req is ignored.
  - FILL: in_ready=1, mem_ren=0. Each wr increments occupancy. A wr that makes occupancy == depth_q moves to STEADY.
  - STEADY: in_ready=1. Each wr also asserts mem_ren with mem_raddr=rptr in the same cycle, so occupancy stays at depth_q.
  - DRAIN: in_ready=0. Assert mem_ren every clk_en cycle, with mem_raddr=rptr. Occupancy decrements by one per read. When occupancy goes 1→0, pulse done and go to IDLE.
- drain_req in FILL or STEADY moves to DRAIN on the next cycle. A write in that same cycle is still accepted, including its paired read in STEADY. drain_req with occupancy==0 in FILL cannot occur.
- Pointers:
  - wptr increments on wr; rptr increments on mem_ren.
  - Each pointer wraps from depth_q-1 to 0, never reaching depth_q.
  - mem_raddr always addresses the oldest word.
- out_valid is mem_ren passed through an RD_LAT-stage shift register gated by clk_en. Entries already in flight at DRAIN→IDLE still emerge.
- full and empty are combinational from occupancy and depth_q.
- Invariants:
  - occupancy ≤ depth_q.
  - Never mem_ren with occupancy==0.
  - Never mem_wen in DRAIN.

Test Plan:
- depth=4, 4 writes → mem_waddr 0,1,2,3, no mem_ren, full=1 after the 4th. 5th write → mem_ren with raddr 0, out_valid one cycle later (RD_LAT=1), occupancy stays 4.
- depth=3, 10 continuous writes → waddr sequence 0,1,2,0,1,2,0,1,2,0. raddr from the 4th write is 0,1,2,0,1,2,0 (rptr trails wptr by 3), never ≥3.
- depth=4, after 6 writes pulse drain_req → 4 consecutive mem_ren with raddr 2,3,0,1, in_ready=0 throughout, done pulses on the 4th, then IDLE with empty=1.
- depth=4, 2 writes, then drain_req → 2 reads with raddr 0,1, done pulse, occupancy 0.
- flush asserted mid-STEADY, and separately reset low mid-DRAIN → next cycle: IDLE, occupancy 0, out_valid 0, pointers 0. A new depth=2 is latched on the next write.
- clk_en low for 3 cycles mid-STEADY with in_valid=1 → no mem_wen/mem_ren, pointers unchanged, and a pending out_valid held. depth=0 → behaves as depth 1: each write after the first pairs with a read at raddr 0.
